// File: rtl/fpu_dispatcher.sv
// fpu_dispatcher: request FIFO feeding the FPU manager one op at a time, result returned over valid/ready.
// Define FPU_DISP_TIMEOUT_EN to bound the wait for fpu_dn and return an error result on expiry.
module fpu_dispatcher #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [2:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  output logic              fpu_q,
  input  logic              fpu_busy,
  input  logic              fpu_dn,
  input  logic [DATA_W-1:0] fpu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [2:0]        op_mem  [DEPTH];
  logic [DATA_W-1:0] a_mem   [DEPTH];
  logic [DATA_W-1:0] b_mem   [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [TAG_W-1:0]  cur_tag;
  logic [2:0]        head_op;
  logic [DATA_W-1:0] head_a, head_b;
  logic [TAG_W-1:0]  head_tag;
  logic              empty, push, issue, done, expire;
  assign empty     = count == '0;
  assign req_ready = count != (AW+1)'(DEPTH);
  assign push      = req_valid && req_ready;
  // An empty FIFO is bypassed so a lone request issues on the cycle it is pushed
  assign issue     = state == IDLE && (!empty || push) && !fpu_busy && (!res_valid || res_ready);
  assign done      = state == WAIT && fpu_dn;
  assign head_op   = empty ? req_op  : op_mem[rd_ptr];
  assign head_a    = empty ? req_a   : a_mem[rd_ptr];
  assign head_b    = empty ? req_b   : b_mem[rd_ptr];
  assign head_tag  = empty ? req_tag : tag_mem[rd_ptr];
`ifdef FPU_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  assign expire = state == WAIT && !fpu_dn && wait_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) wait_cnt <= '0;
    else if (clk_oe) wait_cnt <= issue ? '0 : wait_cnt + 1'b1;
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk)
    if (clk_oe && push) begin
      op_mem[wr_ptr]  <= req_op;
      a_mem[wr_ptr]   <= req_a;
      b_mem[wr_ptr]   <= req_b;
      tag_mem[wr_ptr] <= req_tag;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur_tag   <= '0;
      fpu_q     <= 1'b0;
      fpu_op    <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_err   <= 1'b0;
    end else if (clk_oe) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(issue);
      fpu_q <= issue;
      if (issue) begin
        fpu_op  <= head_op;
        fpu_a   <= head_a;
        fpu_b   <= head_b;
        cur_tag <= head_tag;
      end
      state <= issue ? WAIT : (done || expire) ? IDLE : state;
      if (done || expire) begin
        res_valid <= 1'b1;
        res_data  <= expire ? '0 : fpu_out;
        res_tag   <= cur_tag;
        res_err   <= expire;
      end else if (res_ready) res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fpu_dispatcher.sv
// tb_fpu_dispatcher: directed steps with a result scoreboard and an FPU manager model run from the stimulus process.
module tb_fpu_dispatcher;
  logic        clk = 0, rst = 0, clk_oe = 1, oe_toggle = 0;
  logic        req_valid = 0, fpu_busy = 0, fpu_dn = 0, res_ready = 1;
  logic [2:0]  req_op = 0;
  logic [31:0] req_a = 0, req_b = 0, fpu_out = 0;
  logic [3:0]  req_tag = 0;
  logic        req_ready, fpu_q, res_valid, res_err;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, res_data;
  logic [3:0]  res_tag;
  typedef struct packed {logic [31:0] data; logic [3:0] tag; logic err;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, raw = 0, qcnt = 0, mgr_delay = 6, left = 0;
  bit mgr_mute = 0, man_dn = 0, inflight = 0, dn_n = 0, hold_v = 0;
  logic [2:0]  cap_op;
  logic [31:0] cap_a, cap_b, cap_res, man_out = 0, hold_d;
  logic [3:0]  hold_t;

  fpu_dispatcher dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_q(fpu_q),
    .fpu_busy(fpu_busy), .fpu_dn(fpu_dn), .fpu_out(fpu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    raw++;
    #1 clk_oe = oe_toggle ? !clk_oe : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before 500us");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fmodel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000
           : (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Manager model and result consumer, evaluated once per enabled cycle before its closing edge
  task automatic eval();
    exp_t e;
    dn_n = 1'b0;
    if (fpu_q) qcnt++;
    if (inflight) begin
      chk("held_op", fpu_op, cap_op);
      chk("held_a", fpu_a, cap_a);
      chk("held_b", fpu_b, cap_b);
      if (fpu_dn) inflight = 0;
      else begin left--; dn_n = left == 0; end
    end
    if (fpu_q && !mgr_mute) begin
      inflight = 1; cap_op = fpu_op; cap_a = fpu_a; cap_b = fpu_b;
      cap_res = fmodel(fpu_op, fpu_a, fpu_b);
      left = mgr_delay - 1; dn_n = left == 0;
    end
    if (rst) begin
      if (hold_v) begin
        chk("stall_data", res_data, hold_d);
        chk("stall_tag", res_tag, hold_t);
      end
      hold_v = res_valid && !res_ready; hold_d = res_data; hold_t = res_tag;
      if (res_valid && res_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_result: observed tag %0h expected none", res_tag);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_tag", res_tag, e.tag);
          chk("res_err", res_err, e.err);
        end
      end
    end else hold_v = 0;
  endtask

  task automatic step();
    do @(negedge clk); while (!clk_oe);
    eval();
    @(posedge clk); #2;
    fpu_dn  = dn_n || man_dn;
    fpu_out = dn_n ? cap_res : man_out;
  endtask

  task automatic push_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input bit add);
    int n = 0;
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && n < 200) begin step(); n++; end
    chk("push_accept", req_ready, 1);
    if (add) sb.push_back('{data: fmodel(op, a, b), tag: tag, err: 1'b0});
    step();
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin step(); n++; end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_reset();
    chk("rst_fpu_q", fpu_q, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_tag", res_tag, 0);
  endtask

  task automatic run_single(input int mult);
    int r0, n = 0;
    mgr_delay = 6;
    push_req(3'd0, 32'h3F800000, 32'h40000000, 4'd5, 1);
    chk("issue_q", fpu_q, 1);
    chk("issue_a", fpu_a, 32'h3F800000);
    chk("issue_b", fpu_b, 32'h40000000);
    r0 = raw;
    step();
    chk("q_single_pulse", fpu_q, 0);
    while (!res_valid && n < 50) begin step(); n++; end
    chk("res_latency_raw", raw - r0, 7 * mult);
    chk("single_data", res_data, 32'h40400000);
    chk("single_tag", res_tag, 5);
    drain();
  endtask

  initial begin
    int q0, n;
    #3 chk_reset();
    @(posedge clk); #2;
    rst = 1;
    step(); step();
    run_single(1);
    oe_toggle = 1;
    run_single(2);
    oe_toggle = 0;
    step(); step();
    mgr_delay = 3;
    fpu_busy = 1;
    for (int i = 0; i < 4; i++)
      push_req(3'(i), 32'h100 * i + 1, 32'h55 + i, 4'(i), 1);
    chk("fifo_full_ready", req_ready, 0);
    fpu_busy = 0;
    push_req(3'd1, 32'h401, 32'h59, 4'd4, 1);
    drain();
    mgr_delay = 2;
    res_ready = 0;
    q0 = qcnt;
    push_req(3'd2, 32'hA5A5_0001, 32'h0000_1234, 4'd7, 1);
    push_req(3'd3, 32'h5A5A_0002, 32'h0000_4321, 4'd8, 1);
    n = 0;
    while (!res_valid && n < 50) begin step(); n++; end
    chk("stall_first_tag", res_tag, 7);
    repeat (8) step();
    chk("stall_q_withheld", qcnt - q0, 1);
    chk("stall_valid_held", res_valid, 1);
    res_ready = 1;
    drain();
    chk("stall_second_issued", qcnt - q0, 2);
    mgr_mute = 1;
    push_req(3'd0, 32'h11, 32'h22, 4'd9, 0);
    push_req(3'd1, 32'h33, 32'h44, 4'd12, 0);
    step();
    chk("wait_a", fpu_a, 32'h11);
    rst = 0;
    #1 chk_reset();
    step(); step();
    rst = 1;
    step();
    man_out = 32'hDEAD; man_dn = 1;
    step();
    man_dn = 0;
    step(); step();
    chk("late_dn_ignored", res_valid, 0);
    chk("reset_fifo_empty_q", fpu_q, 0);
    chk("reset_ready", req_ready, 1);
    mgr_mute = 0;
    mgr_delay = 4;
    push_req(3'd2, 32'h77, 32'h88, 4'd10, 1);
    drain();
`ifdef FPU_DISP_TIMEOUT_EN
    mgr_mute = 1;
    push_req(3'd3, 32'h99, 32'hAA, 4'd11, 0);
    sb.push_back('{data: 32'h0, tag: 4'd11, err: 1'b1});
    repeat (63) step();
    chk("to_not_yet", res_valid, 0);
    step();
    chk("to_valid", res_valid, 1);
    chk("to_err", res_err, 1);
    chk("to_data", res_data, 0);
    repeat (5) step();
    man_out = 32'h1234; man_dn = 1;
    step();
    man_dn = 0;
    step(); step();
    chk("to_late_dn_ignored", res_valid, 0);
    mgr_mute = 0;
    drain();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
